// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instruction requests and writes them sequentially into instruction memory
module instr_encoder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  word_count,
  output logic        done,
  output logic        full,
  output logic        err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  logic [1:0]  state;
  logic [31:0] addr;
  logic        last_q;
  logic        legal;
  logic        r_type;
  logic        i_type;
  logic        j_type;
  logic [5:0]  func;
  logic [5:0]  i_opc;
  logic [31:0] enc;
  logic [8:0]  wc_next;
  logic        hit_depth;
  always_comb begin
    legal  = op_sel <= 4'd12;
    r_type = op_sel <= 4'd4;
    i_type = (op_sel >= 4'd5 && op_sel <= 4'd8) || op_sel == 4'd12;
    j_type = op_sel == 4'd9 || op_sel == 4'd10;
    func   = op_sel == 4'd0 ? 6'b100000 :
             op_sel == 4'd1 ? 6'b100010 :
             op_sel == 4'd2 ? 6'b100100 :
             op_sel == 4'd3 ? 6'b100101 : 6'b101010;
    i_opc  = op_sel == 4'd5 ? 6'b001000 :
             op_sel == 4'd6 ? 6'b001010 :
             op_sel == 4'd7 ? 6'b100011 :
             op_sel == 4'd8 ? 6'b101011 : 6'b000100;
    // jr is the fall-through; illegal codes also land here but are never written
    enc    = r_type ? {6'b000000, rs, rt, rd, 5'b00000, func} :
             i_type ? {i_opc, rs, rt, imm} :
             j_type ? {5'b00001, op_sel == 4'd10, target} :
                      {6'b111111, rs, 21'b0};
    wc_next   = word_count + 9'd1;
    hit_depth = wc_next == DEPTH_W;
  end
  assign in_ready = state == LOAD;
  assign mem_we   = state == WRITE;
  assign done     = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      last_q     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr       <= base_addr;
          word_count <= '0;
          full       <= 1'b0;
          err        <= 1'b0;
          state      <= LOAD;
        end
        LOAD: if (in_valid) begin
          if (legal) begin
            mem_addr  <= addr;
            mem_wdata <= enc;
            last_q    <= in_last;
            state     <= WRITE;
          end else begin
            err <= 1'b1;
            if (in_last) state <= DONE;
          end
        end
        WRITE: begin
          addr       <= addr + 32'd4;
          word_count <= wc_next;
          if (hit_depth) full <= 1'b1;
          state      <= (last_q || hit_depth) ? DONE : LOAD;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven encoding sessions with a write scoreboard, plus handshake, capacity and reset corner cases
module tb_instr_encoder;
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
  logic [31:0] base_addr = '0;
  logic [3:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic in_ready, mem_we, done, full, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [8:0]  word_count;
  logic in_ready4, mem_we4, done4, full4, err4;
  logic [31:0] mem_addr4, mem_wdata4;
  logic [8:0]  word_count4;
  int n_cmp = 0, n_bad = 0, n4 = 0, done4_cnt = 0;
  bit chk4 = 0;
  logic [31:0] exp_addr;
  wr_t q[$], q4[$];
  vec_t tv[13];
  vec_t bad;
  always #5 clk = ~clk;
  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .done(done), .full(full), .err(err)
  );
  instr_encoder #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready4), .in_last(in_last), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .word_count(word_count4), .done(done4), .full(full4), .err(err4)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    wr_t w;
    if (mem_we) begin
      if (q.size() == 0) chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      else begin
        w = q.pop_front();
        chk("write_addr", mem_addr, w.a);
        chk("write_data", mem_wdata, w.d);
      end
    end
    if (chk4 && mem_we4) begin
      n4++;
      if (q4.size() == 0) chk("unexpected_write4", mem_addr4, 32'hFFFF_FFFF);
      else begin
        w = q4.pop_front();
        chk("write4_addr", mem_addr4, w.a);
        chk("write4_data", mem_wdata4, w.d);
      end
    end
    if (chk4 && done4) done4_cnt++;
  end
  task automatic drive(input vec_t v);
    op_sel = v.op; rs = v.rs; rt = v.rt; rd = v.rd; imm = v.imm; target = v.tgt;
  endtask
  task automatic begin_session(input logic [31:0] b);
    start = 1; base_addr = b; exp_addr = b;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input vec_t v, input bit last, input bit legal, input bit push4);
    int n = 0;
    drive(v); in_last = last; in_valid = 1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    if (legal) begin
      q.push_back('{exp_addr, v.exp});
      if (push4) q4.push_back('{exp_addr, v.exp});
      exp_addr += 4;
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("sb_drained", q.size(), 0);
  endtask
  task automatic reset_all();
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820};
    tv[1]  = '{4'd7,  5'd0,  5'd8,  5'd31, 16'h0004, 26'h3FFFFFF, 32'h8C080004};
    tv[2]  = '{4'd9,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h08000010};
    tv[3]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'hABCD, 26'h1555555, 32'h00853022};
    tv[4]  = '{4'd11, 5'd31, 5'd7,  5'd9,  16'h1234, 26'h2AAAAAA, 32'hFFE00000};
    tv[5]  = '{4'd12, 5'd1,  5'd2,  5'd17, 16'hFFFF, 26'h3FFFFFF, 32'h1022FFFF};
    tv[6]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h00E84824};
    tv[7]  = '{4'd3,  5'd10, 5'd11, 5'd12, 16'h5555, 26'h0000000, 32'h014B6025};
    tv[8]  = '{4'd4,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03FFF82A};
    tv[9]  = '{4'd5,  5'd3,  5'd4,  5'd31, 16'h8000, 26'h3FFFFFF, 32'h20648000};
    tv[10] = '{4'd6,  5'd5,  5'd6,  5'd31, 16'h0001, 26'h3FFFFFF, 32'h28A60001};
    tv[11] = '{4'd8,  5'd2,  5'd5,  5'd31, 16'h0008, 26'h3FFFFFF, 32'hAC450008};
    tv[12] = '{4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0FFFFFFF};
    bad    = '{4'd14, 5'd1,  5'd1,  5'd1,  16'h0000, 26'h0000000, 32'h0};
    #2 rst = 0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_hold_ready", in_ready, 0);
    chk("idle_hold_done", done, 0);
    begin_session(32'h100);
    chk("load_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) send(tv[i], i == 2, 1, 0);
    wait_done();
    chk("s1_word_count", word_count, 3);
    chk("s1_err", err, 0);
    chk("s1_full", full, 0);
    begin_session(32'hFFFF_FFF8);
    chk("s2_count_cleared", word_count, 0);
    for (int i = 3; i < 13; i++) send(tv[i], i == 12, 1, 0);
    wait_done();
    chk("s2_word_count", word_count, 10);
    chk("s2_hold_addr", mem_addr, 32'h0000_001C);
    begin_session(32'h300);
    send(bad, 0, 0, 0);
    chk("illegal_err", err, 1);
    chk("illegal_stay_load", in_ready, 1);
    chk("illegal_no_count", word_count, 0);
    send(tv[11], 1, 1, 0);
    wait_done();
    chk("ill_err_sticky", err, 1);
    chk("ill_word_count", word_count, 1);
    begin_session(32'h0);
    chk("start_clears_err", err, 0);
    bad.op = 4'd15;
    send(bad, 1, 0, 0);
    wait_done();
    chk("illegal_last_count", word_count, 0);
    chk("illegal_last_err", err, 1);
    begin_session(32'h500);
    in_valid = 1;
    for (int c = 0, k = 0; c < 5; c++) begin
      chk("hs_ready_toggle", in_ready, (c % 2 == 0) ? 1 : 0);
      if (in_ready) begin
        drive(tv[k]);
        q.push_back('{exp_addr, tv[k].exp});
        exp_addr += 4;
        k++;
      end
      if (c == 2) begin start = 1; base_addr = 32'hDEAD_0000; end
      if (c == 4) start = 0;
      @(negedge clk);
    end
    in_valid = 0;
    @(negedge clk);
    chk("hs_word_count", word_count, 3);
    send(tv[12], 1, 1, 0);
    wait_done();
    chk("hs_final_count", word_count, 4);
    reset_all();
    chk4 = 1;
    begin_session(32'h1000);
    for (int i = 0; i < 6; i++) send(tv[3 + i], 0, 1, i < 4);
    repeat (3) @(negedge clk);
    chk("d4_writes", n4, 4);
    chk("d4_sb_drained", q4.size(), 0);
    chk("d4_full", full4, 1);
    chk("d4_done_pulses", done4_cnt, 1);
    chk("d4_ready_after", in_ready4, 0);
    chk("d4_word_count", word_count4, 4);
    chk("main_not_full", full, 0);
    chk("main_word_count", word_count, 6);
    chk("main_sb_drained", q.size(), 0);
    chk4 = 0;
    reset_all();
    begin_session(32'h200);
    drive(tv[0]); in_valid = 1;
    @(posedge clk);
    #1 chk("rw_we_high", mem_we, 1);
    in_valid = 0;
    #1 rst = 0;
    #1;
    chk("rw_we_drop", mem_we, 0);
    chk("rw_addr_zero", mem_addr, 0);
    chk("rw_data_zero", mem_wdata, 0);
    chk("rw_ready_zero", in_ready, 0);
    chk("rw_count_zero", word_count, 0);
    chk("rw_flags_zero", {done, full, err}, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rw_no_write", q.size(), 0);
    begin_session(32'h40);
    send(tv[4], 1, 1, 0);
    wait_done();
    chk("rw_resume_count", word_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
